// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Word-addressed memory model with a fixed-latency read return
//             path, single-cycle writes, request counters and a sticky
//             out-of-range address flag. No backpressure: a read and a write
//             may be accepted in every cycle.
//
//  Ports
//    clk         in   1    rising-edge clock
//    reset_n     in   1    asynchronous active-low reset
//    init_pulse  in   1    job start; clears counters and error flag
//    raddr       in   AW   read word address
//    raddr_vld   in   1    read request strobe
//    rdata       out  DW   read data (holds while rdata_vld is low)
//    rdata_vld   out  1    read data valid, one cycle per request
//    waddr       in   AW   write word address
//    wdata       in   DW   write data
//    wdata_vld   in   1    write strobe
//    rd_cnt      out  AW   reads accepted since init_pulse/reset (wraps)
//    wr_cnt      out  AW   writes accepted since init_pulse/reset (wraps)
//    addr_err    out  1    sticky out-of-range read/write indication
//
//  Revision : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int AW        = 16,
    parameter int DW        = 512,
    parameter int DEPTH     = 1024,
    parameter int MEM_DELAY = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init_pulse,
    input  logic [AW-1:0] raddr,
    input  logic          raddr_vld,
    output logic [DW-1:0] rdata,
    output logic          rdata_vld,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          wdata_vld,
    output logic [AW-1:0] rd_cnt,
    output logic [AW-1:0] wr_cnt,
    output logic          addr_err
);

    // Index width into the storage array. DEPTH <= 2^AW guarantees it never
    // exceeds AW, so the low address bits can be used directly once the
    // full address has been range checked.
    localparam int          c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH widened by one bit so DEPTH == 2^AW still compares correctly.
    localparam logic [AW:0] c_depth_ext = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic               w_rd_in_range;
    logic               w_wr_in_range;
    logic [c_idx_w-1:0] w_ridx;
    logic [c_idx_w-1:0] w_widx;
    logic               w_wr_en;
    logic               w_err_now;
    logic [DW-1:0]      w_rd_word;

    assign w_rd_in_range = ({1'b0, raddr} < c_depth_ext);
    assign w_wr_in_range = ({1'b0, waddr} < c_depth_ext);
    assign w_ridx        = raddr[c_idx_w-1:0];
    assign w_widx        = waddr[c_idx_w-1:0];

    // Writes are ignored while reset is held; out-of-range writes dropped.
    assign w_wr_en   = reset_n & wdata_vld & w_wr_in_range;
    assign w_err_now = (raddr_vld & ~w_rd_in_range) | (wdata_vld & ~w_wr_in_range);

    // ------------------------------------------------------------------
    // Storage array (intentionally not reset)
    // ------------------------------------------------------------------
    logic [DW-1:0] mem_q [DEPTH];

    // Out-of-range reads return zero rather than aliasing into the array.
    assign w_rd_word = w_rd_in_range ? mem_q[w_ridx] : '0;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[w_widx] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline
    //   Stage 0 samples the array at the request edge; because the array
    //   update is non-blocking, a same-edge write to the same address is
    //   not visible here and the pre-write word is returned. The last
    //   stage drives the outputs. Data registers only load when a valid
    //   word arrives, so rdata holds its last value between responses.
    // ------------------------------------------------------------------
    logic [MEM_DELAY-1:0] vld_q;
    logic [DW-1:0]        data_q [MEM_DELAY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < MEM_DELAY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= raddr_vld;
            if (raddr_vld) begin
                data_q[0] <= w_rd_word;
            end
            for (int i = 1; i < MEM_DELAY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign rdata_vld = vld_q[MEM_DELAY-1];
    assign rdata     = data_q[MEM_DELAY-1];

    // ------------------------------------------------------------------
    // Request counters and sticky error flag
    //   init_pulse restarts the job: a request in that same cycle is the
    //   first one of the new job, so counters load 0/1 instead of clearing.
    // ------------------------------------------------------------------
    logic [AW-1:0] rd_cnt_q;
    logic [AW-1:0] rd_cnt_d;
    logic [AW-1:0] wr_cnt_q;
    logic [AW-1:0] wr_cnt_d;
    logic          addr_err_q;
    logic          addr_err_d;

    always_comb begin
        rd_cnt_d   = rd_cnt_q + AW'(raddr_vld);
        wr_cnt_d   = wr_cnt_q + AW'(wdata_vld);
        addr_err_d = addr_err_q | w_err_now;
        if (init_pulse) begin
            rd_cnt_d   = AW'(raddr_vld);
            wr_cnt_d   = AW'(wdata_vld);
            addr_err_d = w_err_now;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign addr_err = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder. A transaction-level
//             reference model (word array plus a scoreboard of expected
//             responses keyed by the edge at which they must be seen)
//             checks every cycle; directed table vectors and hand-written
//             sequences cover the boundary cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int AW        = 11;
    localparam int DW        = 64;
    localparam int DEPTH     = 1024;
    localparam int MEM_DELAY = 8;
    localparam int c_mask    = (1 << AW) - 1;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b1;
    logic          init_pulse = 1'b0;
    logic [AW-1:0] raddr      = '0;
    logic          raddr_vld  = 1'b0;
    logic [DW-1:0] rdata;
    logic          rdata_vld;
    logic [AW-1:0] waddr      = '0;
    logic [DW-1:0] wdata      = '0;
    logic          wdata_vld  = 1'b0;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] wr_cnt;
    logic          addr_err;

    mem_responder #(
        .AW        (AW),
        .DW        (DW),
        .DEPTH     (DEPTH),
        .MEM_DELAY (MEM_DELAY)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .init_pulse (init_pulse),
        .raddr      (raddr),
        .raddr_vld  (raddr_vld),
        .rdata      (rdata),
        .rdata_vld  (rdata_vld),
        .waddr      (waddr),
        .wdata      (wdata),
        .wdata_vld  (wdata_vld),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int            n_tests    = 0;
    int            n_fail     = 0;
    int            edge_no    = 0;
    int            n_vld_seen = 0;
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    int            m_rd     = 0;
    int            m_wr     = 0;
    bit            m_err    = 1'b0;
    logic [DW-1:0] m_hold   = '0;
    bit            m_hold_k = 1'b1;
    bit            sb_v [int];
    logic [DW-1:0] sb_d [int];
    bit            sb_k [int];

    typedef struct {
        bit            rv;
        int            ra;
        bit            wv;
        int            wa;
        logic [DW-1:0] wd;
        bit            ip;
        int            e_rd;
        int            e_wr;
        bit            e_err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_no);
        end
    endtask

    // Called between edges: drives the request for the next edge and
    // records its architectural effect in the model.
    task automatic drive(input bit rv, input int ra, input bit wv, input int wa,
                         input logic [DW-1:0] wd, input bit ip);
        int key;
        bit err_now;
        raddr_vld  = rv;
        raddr      = AW'(ra);
        wdata_vld  = wv;
        waddr      = AW'(wa);
        wdata      = wd;
        init_pulse = ip;
        // Sampled at edge edge_no+1, visible for sampling at edge +MEM_DELAY.
        key = edge_no + 1 + MEM_DELAY;
        if (rv) begin
            sb_v[key] = 1'b1;
            if (ra < DEPTH) begin
                sb_d[key] = m_mem[ra];
                sb_k[key] = m_known[ra];
            end else begin
                sb_d[key] = '0;
                sb_k[key] = 1'b1;
            end
        end
        if (wv && wa < DEPTH) begin
            m_mem[wa]   = wd;
            m_known[wa] = 1'b1;
        end
        err_now = (rv && ra >= DEPTH) || (wv && wa >= DEPTH);
        if (ip) begin
            m_rd  = int'(rv);
            m_wr  = int'(wv);
            m_err = err_now;
        end else begin
            m_rd  = (m_rd + int'(rv)) & c_mask;
            m_wr  = (m_wr + int'(wv)) & c_mask;
            m_err = m_err | err_now;
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, '0, 1'b0);
    endtask

    // Advance one edge, then compare all outputs at the falling edge.
    task automatic tick();
        int key;
        bit exp_v;
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        key   = edge_no + 1;
        exp_v = sb_v.exists(key);
        if (exp_v) begin
            m_hold   = sb_d[key];
            m_hold_k = sb_k[key];
            sb_v.delete(key);
            sb_d.delete(key);
            sb_k.delete(key);
        end
        if (rdata_vld === 1'b1) n_vld_seen++;
        chk("rdata_vld", DW'(rdata_vld), DW'(exp_v));
        if (m_hold_k) chk("rdata", rdata, m_hold);
        chk("rd_cnt", DW'(rd_cnt), DW'(m_rd));
        chk("wr_cnt", DW'(wr_cnt), DW'(m_wr));
        chk("addr_err", DW'(addr_err), DW'(m_err));
    endtask

    task automatic model_reset();
        sb_v.delete();
        sb_d.delete();
        sb_k.delete();
        m_rd     = 0;
        m_wr     = 0;
        m_err    = 1'b0;
        m_hold   = '0;
        m_hold_k = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_vld"},  DW'(rdata_vld), '0);
        chk({tag, "_data"}, rdata, '0);
        chk({tag, "_rd"},   DW'(rd_cnt), '0);
        chk({tag, "_wr"},   DW'(wr_cnt), '0);
        chk({tag, "_err"},  DW'(addr_err), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int v0;

        // Directed vectors: {rv, ra, wv, wa, wd, ip, rd_cnt, wr_cnt, addr_err}
        tbl[0]  = '{1'b0, 0,    1'b0, 0,    64'h0,    1'b1, 0, 0, 1'b0};
        tbl[1]  = '{1'b0, 0,    1'b1, 5,    64'h11,   1'b0, 0, 1, 1'b0};
        tbl[2]  = '{1'b1, 5,    1'b1, 5,    64'h22,   1'b0, 1, 2, 1'b0};
        tbl[3]  = '{1'b1, 5,    1'b0, 0,    64'h0,    1'b0, 2, 2, 1'b0};
        tbl[4]  = '{1'b1, 1024, 1'b1, 1025, 64'hDEAD, 1'b1, 1, 1, 1'b1};
        tbl[5]  = '{1'b1, 1,    1'b0, 0,    64'h0,    1'b0, 2, 1, 1'b1};
        tbl[6]  = '{1'b1, 8,    1'b0, 0,    64'h0,    1'b0, 3, 1, 1'b1};
        tbl[7]  = '{1'b1, 9,    1'b0, 0,    64'h0,    1'b0, 4, 1, 1'b1};
        tbl[8]  = '{1'b1, 10,   1'b0, 0,    64'h0,    1'b0, 5, 1, 1'b1};
        tbl[9]  = '{1'b1, 7,    1'b0, 0,    64'h0,    1'b1, 1, 0, 1'b0};
        tbl[10] = '{1'b0, 0,    1'b0, 0,    64'h0,    1'b0, 1, 0, 1'b0};
        tbl[11] = '{1'b0, 0,    1'b1, 1500, 64'h5,    1'b1, 0, 1, 1'b1};
        tbl[12] = '{1'b0, 0,    1'b0, 0,    64'h0,    1'b1, 0, 0, 1'b0};

        // Power-on reset
        #1 reset_n = 1'b0;
        model_reset();
        #1 chk_zero_outputs("reset");
        repeat (3) tick();
        reset_n = 1'b1;

        // Preload data = address, twice: the second pass wraps wr_cnt to 0
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                drive(1'b0, 0, 1'b1, i, DW'(i), 1'b0);
                tick();
            end
        end
        chk("wr_wrap", DW'(wr_cnt), '0);
        chk("wr_wrap_err", DW'(addr_err), '0);

        // 16 back-to-back reads of 0..15
        v0 = n_vld_seen;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i, 1'b0, 0, '0, 1'b0);
            tick();
        end
        repeat (MEM_DELAY + 4) begin idle(); tick(); end
        chk("b2b_count", DW'(n_vld_seen - v0), DW'(16));

        // Write then read next cycle: exact latency
        drive(1'b0, 0, 1'b1, 3, {8{8'hA5}}, 1'b0);
        tick();
        drive(1'b1, 3, 1'b0, 0, '0, 1'b0);
        tick();
        k = 0;
        while (rdata_vld !== 1'b1 && k < 20) begin
            idle();
            tick();
            k++;
        end
        chk("wr_rd_latency", DW'(k), DW'(MEM_DELAY - 1));
        chk("wr_rd_data", rdata, {8{8'hA5}});
        repeat (4) begin idle(); tick(); end

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rv, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].ip);
            tick();
            chk($sformatf("tbl%0d_rd", i),  DW'(rd_cnt),   DW'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_wr", i),  DW'(wr_cnt),   DW'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_err", i), DW'(addr_err), DW'(tbl[i].e_err));
        end
        repeat (MEM_DELAY + 4) begin idle(); tick(); end

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 4) != 0, int'($urandom_range(1100, 0)),
                  ($urandom % 3) != 0, int'($urandom_range(1100, 0)),
                  {$urandom, $urandom}, ($urandom % 25) == 0);
            tick();
        end
        repeat (MEM_DELAY + 4) begin idle(); tick(); end

        // Reset with reads in flight
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 20 + i, 1'b0, 0, '0, 1'b0);
            tick();
        end
        idle();
        tick();
        #2;
        reset_n   = 1'b0;
        raddr_vld = 1'b1;
        raddr     = AW'(4);
        wdata_vld = 1'b1;
        waddr     = AW'(4);
        #1 chk_zero_outputs("async_rst");
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        v0 = n_vld_seen;
        drive(1'b0, 0, 1'b1, 2, 64'h77, 1'b0);
        tick();
        chk("first_after_rst", DW'(wr_cnt), DW'(1));
        drive(1'b1, 2, 1'b0, 0, '0, 1'b0);
        tick();
        repeat (MEM_DELAY + 4) begin idle(); tick(); end
        chk("post_rst_vld_count", DW'(n_vld_seen - v0), DW'(1));
        chk("post_rst_data", rdata, 64'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
- REQ-001 Parameter AW, default 16: address width in bits.
- REQ-002 Parameter DW, default 512: data word width in bits.
- REQ-003 Parameter DEPTH, default 1024: number of DW-bit words stored; DEPTH <= 2^AW.
- REQ-004 Parameter MEM_DELAY, default 8: read latency in cycles; legal range 1..32.
- REQ-005 clk  input  1  single clock; all logic on rising edge.
- REQ-006 reset_n  input  1  asynchronous, active-low reset.
- REQ-007 init_pulse  input  1  one-cycle job start; clears counters and error flag.
- REQ-008 raddr  input  AW  word read address.
- REQ-009 raddr_vld  input  1  read request strobe, one request per cycle high.
- REQ-010 rdata  output  DW  read data.
- REQ-011 rdata_vld  output  1  read data valid, one cycle per request.
- REQ-012 waddr  input  AW  word write address.
- REQ-013 wdata  input  DW  write data.
- REQ-014 wdata_vld  input  1  write strobe, one write per cycle high.
- REQ-015 rd_cnt  output  AW  read requests accepted since last init_pulse/reset.
- REQ-016 wr_cnt  output  AW  writes accepted since last init_pulse/reset.
- REQ-017 addr_err  output  1  sticky: any out-of-range read or write seen.

Function
- REQ-018 Every request is accepted unconditionally (no backpressure); raddr_vld and wdata_vld may be high in every cycle, including together.
- REQ-019 A read sampled at edge T drives rdata_vld=1 for exactly one cycle at edge T+MEM_DELAY, with rdata = word at raddr.
- REQ-020 Back-to-back reads return back-to-back in request order; gaps in requests appear as identical gaps in rdata_vld.
- REQ-021 The read pipeline is a MEM_DELAY-stage valid/data shift chain; the storage array read occurs in stage 1.
- REQ-022 A write sampled at edge T updates the array at edge T; a read of that address sampled at T+1 or later returns the new data.
- REQ-023 Read and write to the same address sampled at the same edge: the read returns the old (pre-write) data.
- REQ-024 Address >= DEPTH on a read: rdata = 0 when delivered, rdata_vld still asserted with normal latency, addr_err set.
- REQ-025 Address >= DEPTH on a write: write dropped, array unchanged, addr_err set.
- REQ-026 rdata holds its last value while rdata_vld=0.
- REQ-027 rd_cnt/wr_cnt increment by 1 per accepted request (out-of-range included); wrap 2^AW-1 -> 0 with no flag.
- REQ-028 init_pulse clears rd_cnt, wr_cnt and addr_err at the next edge; a request sampled in that same cycle counts as 1 (counter = 1, not 0) and an error in that cycle leaves addr_err = 1.
- REQ-029 init_pulse does not flush the read pipeline and does not alter array contents; in-flight reads complete normally.

Reset
- REQ-030 reset_n low asynchronously forces rdata_vld=0, rdata=0, rd_cnt=0, wr_cnt=0, addr_err=0 and clears all pipeline valid bits.
- REQ-031 The storage array is not reset; contents are undefined until written.
- REQ-032 Reads in flight when reset asserts are discarded; no rdata_vld appears after reset release for them.
- REQ-033 Inputs are ignored while reset_n is low; the first request is accepted at the first edge with reset_n high.

Verification
- REQ-034 Write 0xA5..A5 to addr 3 at T, read addr 3 at T+1 (MEM_DELAY=8) -> rdata_vld=1 with 0xA5..A5 at T+9 only.
- REQ-035 16 consecutive reads of addrs 0..15 after preload data=addr -> 16 consecutive rdata_vld cycles, data 0..15 in order.
- REQ-036 Read and write addr 5 in same cycle (old 0x11, new 0x22) -> returned data 0x11; a later read returns 0x22.
- REQ-037 Read addr DEPTH and write addr DEPTH+1 -> rdata=0 delivered with normal latency, addr_err=1, array unchanged, rd_cnt=1, wr_cnt=1.
- REQ-038 4 reads issued, reset_n pulsed low 2 cycles later -> outputs zero immediately, no rdata_vld after release, counters 0.
- REQ-039 init_pulse with 3 reads in flight and a read in the same cycle -> all 4 reads return, rd_cnt=1, addr_err=0 afterwards.
